// File: rtl/cartridge_bus_responder.sv
// Cartridge-side Game Boy bus responder: syncs the async bus, decodes ROM/RAM hits,
// issues valid/ready memory requests and drives read data through cart_d_oe.
// Ports: clock/reset, cart_* bus (in), cart_d_out/oe (out), mem_req_* / mem_resp_* (backing store),
//        busy (FSM not idle), late_read (read response discarded pulse).
module cartridge_bus_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ENABLE_RAM    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cart_a_in,
  input  logic [7:0]  cart_d_in,
  input  logic        cart_nrd_in,
  input  logic        cart_nwr_in,
  input  logic        cart_ncs_in,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [15:0] mem_req_addr,
  output logic [7:0]  mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [7:0]  mem_resp_rdata,
  output logic        busy,
  output logic        late_read
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, RD_REQ, RD_WAIT, DRIVE, WR_LOW, WR_REQ
  } state_t;

  localparam int W  = 27;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // strobes and nCS idle high, address/data idle low
  localparam logic [W-1:0] SYNC_RST = {3'b111, 24'h0};
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  // all bus inputs share one synchroniser chain: {ncs, nwr, nrd, d, a}
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] bus_s;
  logic [15:0]  a_s;
  logic [7:0]   d_s;
  logic         nrd_s;
  logic         nwr_s;
  logic         ncs_s;
  logic         nwr_q;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   cap_a, cap_a_n;
  logic [7:0]    cap_d, cap_d_n;
  logic [7:0]    d_out, d_out_n;

  logic hit;
  logic same_a;
  logic rd_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      nwr_q <= 1'b1;
    end else begin
      sync_q[0] <= {cart_ncs_in, cart_nwr_in, cart_nrd_in,
                    cart_d_in, cart_a_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      nwr_q <= nwr_s;
    end
  end

  assign bus_s = sync_q[SYNC_STAGES-1];
  assign a_s   = bus_s[15:0];
  assign d_s   = bus_s[23:16];
  assign nrd_s = bus_s[24];
  assign nwr_s = bus_s[25];
  assign ncs_s = bus_s[26];

  assign hit = ~a_s[15]
             | ((ENABLE_RAM != 0) & ~ncs_s & (a_s[15:13] == 3'b101));
  assign same_a  = (a_s == cap_a);
  // a read stays legitimate only while the same address is still being read
  assign rd_hold = ~nrd_s & nwr_s & same_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap_a <= '0;
      cap_d <= '0;
      d_out <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cap_a <= cap_a_n;
      cap_d <= cap_d_n;
      d_out <= d_out_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cap_a_n       = cap_a;
    cap_d_n       = cap_d;
    d_out_n       = d_out;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    cart_d_oe     = 1'b0;
    late_read     = 1'b0;
    unique case (state)
      IDLE: begin
        // write wins when a write edge and a read appear together
        if (nwr_q & ~nwr_s & hit) begin
          state_n = WR_LOW;
          cap_a_n = a_s;
          cap_d_n = d_s;
        end else if (~nrd_s & nwr_s & hit) begin
          state_n = SETTLE;
          cnt_n   = '0;
          cap_a_n = a_s;
        end
      end
      SETTLE: begin
        if (nrd_s | ~nwr_s) begin
          state_n = IDLE;
        end else if (!same_a) begin
          if (hit) begin
            cap_a_n = a_s;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = RD_REQ;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          d_out_n = mem_resp_rdata;
          if (rd_hold) begin
            state_n = DRIVE;
          end else begin
            late_read = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      DRIVE: begin
        if (rd_hold) cart_d_oe = 1'b1;
        else state_n = IDLE;
      end
      WR_LOW: begin
        // keep the last values seen while nWR was still low
        if (~nwr_s) begin
          cap_a_n = a_s;
          cap_d_n = d_s;
        end else begin
          state_n = WR_REQ;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cart_d_out    = d_out;
  assign mem_req_addr  = cap_a;
  assign mem_req_wdata = cap_d;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_cartridge_bus_responder.sv
// Directed bench for cartridge_bus_responder: ROM/RAM reads, writes, glitches,
// back-pressure with late responses and reset in the middle of a read.
module tb_cartridge_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] a_in;
  logic [7:0]  d_in;
  logic        nrd, nwr, ncs;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        busy, late;

  logic [7:0]  d_out2;
  logic        d_oe2, req_valid2, req_write2, busy2, late2;
  logic [15:0] req_addr2;
  logic [7:0]  req_wdata2;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int oe_cnt = 0;
  int late_cnt = 0;
  int v2_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;
  logic        last_write = 1'b0;

  cartridge_bus_responder dut (
    .clock(clock), .reset(reset),
    .cart_a_in(a_in), .cart_d_in(d_in),
    .cart_nrd_in(nrd), .cart_nwr_in(nwr), .cart_ncs_in(ncs),
    .cart_d_out(d_out), .cart_d_oe(d_oe),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready),
    .mem_req_write(req_write), .mem_req_addr(req_addr),
    .mem_req_wdata(req_wdata),
    .mem_resp_valid(resp_valid), .mem_resp_rdata(resp_rdata),
    .busy(busy), .late_read(late)
  );

  cartridge_bus_responder #(.ENABLE_RAM(0)) dut_rom (
    .clock(clock), .reset(reset),
    .cart_a_in(a_in), .cart_d_in(d_in),
    .cart_nrd_in(nrd), .cart_nwr_in(nwr), .cart_ncs_in(ncs),
    .cart_d_out(d_out2), .cart_d_oe(d_oe2),
    .mem_req_valid(req_valid2), .mem_req_ready(req_ready),
    .mem_req_write(req_write2), .mem_req_addr(req_addr2),
    .mem_req_wdata(req_wdata2),
    .mem_resp_valid(resp_valid), .mem_resp_rdata(resp_rdata),
    .busy(busy2), .late_read(late2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        req_cnt    <= req_cnt + 1;
        last_addr  <= req_addr;
        last_write <= req_write;
        last_wdata <= req_wdata;
      end
      if (d_oe) oe_cnt <= oe_cnt + 1;
      if (late) late_cnt <= late_cnt + 1;
      if (req_valid2) v2_cnt <= v2_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    a_in       = '0;
    d_in       = '0;
    nrd        = 1'b1;
    nwr        = 1'b1;
    ncs        = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, req_valid}, 1);
  endtask

  task automatic respond(logic [7:0] v);
    resp_valid = 1'b1;
    resp_rdata = v;
    tick();
    resp_valid = 1'b0;
  endtask

  int base_req, base_oe, base_late, base_v2, n;

  initial begin
    // reset state
    do_reset();
    chk("rst_oe", {31'b0, d_oe}, 0);
    chk("rst_valid", {31'b0, req_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_dout", {24'b0, d_out}, 0);
    chk("rst_addr", {16'b0, req_addr}, 0);
    chk("rst_late", {31'b0, late}, 0);

    // ROM read 0x0150 -> 0x3C
    base_req = req_cnt;
    req_ready = 1'b1;
    a_in = 16'h0150;
    nrd  = 1'b0;
    wait_valid("t1_valid");
    chk("t1_addr", {16'b0, req_addr}, 32'h0150);
    tick();
    respond(8'h3C);
    chk("t1_oe", {31'b0, d_oe}, 1);
    chk("t1_dout", {24'b0, d_out}, 32'h3C);
    repeat (3) tick();
    chk("t1_oe_hold", {31'b0, d_oe}, 1);
    nrd = 1'b1;
    n = 0;
    while (d_oe && n < 10) begin
      tick();
      n++;
    end
    chk("t1_oe_release", {31'b0, (n <= 3)}, 1);
    repeat (3) tick();
    chk("t1_idle", {31'b0, busy}, 0);
    chk("t1_nreq", req_cnt - base_req, 1);
    chk("t1_lwrite", {31'b0, last_write}, 0);
    chk("t1_laddr", {16'b0, last_addr}, 32'h0150);

    // write 0x2000 <- 0x05, nWR low 4 cycles
    do_reset();
    base_req = req_cnt;
    base_oe  = oe_cnt;
    req_ready = 1'b1;
    a_in = 16'h2000;
    d_in = 8'h05;
    nwr  = 1'b0;
    repeat (4) tick();
    nwr = 1'b1;
    repeat (10) tick();
    chk("t2_nreq", req_cnt - base_req, 1);
    chk("t2_write", {31'b0, last_write}, 1);
    chk("t2_addr", {16'b0, last_addr}, 32'h2000);
    chk("t2_wdata", {24'b0, last_wdata}, 32'h05);
    chk("t2_no_oe", oe_cnt - base_oe, 0);

    // RAM window 0xA010
    do_reset();
    base_req = req_cnt;
    base_v2  = v2_cnt;
    req_ready = 1'b1;
    a_in = 16'hA010;
    ncs  = 1'b1;
    nrd  = 1'b0;
    repeat (12) tick();
    chk("t3_ncs_high", req_cnt - base_req, 0);
    nrd = 1'b1;
    repeat (4) tick();
    ncs = 1'b0;
    nrd = 1'b0;
    wait_valid("t3_valid");
    chk("t3_addr", {16'b0, req_addr}, 32'hA010);
    tick();
    respond(8'h77);
    chk("t3_oe", {31'b0, d_oe}, 1);
    chk("t3_dout", {24'b0, d_out}, 32'h77);
    chk("t3_nreq", req_cnt - base_req, 1);
    chk("t3_rom_only", v2_cnt - base_v2, 0);
    nrd = 1'b1;
    repeat (4) tick();

    // address glitch during settle
    do_reset();
    base_req = req_cnt;
    req_ready = 1'b1;
    a_in = 16'h0100;
    nrd  = 1'b0;
    repeat (2) tick();
    a_in = 16'h0101;
    wait_valid("t4_valid");
    chk("t4_addr", {16'b0, req_addr}, 32'h0101);
    tick();
    respond(8'h11);
    nrd = 1'b1;
    repeat (6) tick();
    chk("t4_nreq", req_cnt - base_req, 1);
    chk("t4_laddr", {16'b0, last_addr}, 32'h0101);

    // back-pressure then late response
    do_reset();
    base_oe   = oe_cnt;
    base_late = late_cnt;
    req_ready = 1'b0;
    a_in = 16'h0200;
    nrd  = 1'b0;
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'b0, req_valid}, 1);
      chk("t5_hold_addr", {16'b0, req_addr}, 32'h0200);
      chk("t5_hold_write", {31'b0, req_write}, 0);
      tick();
    end
    nrd = 1'b1;
    req_ready = 1'b1;
    tick();
    repeat (3) tick();
    resp_valid = 1'b1;
    resp_rdata = 8'h5A;
    #3;
    chk("t5_late_now", {31'b0, late}, 1);
    tick();
    resp_valid = 1'b0;
    chk("t5_late_off", {31'b0, late}, 0);
    chk("t5_idle", {31'b0, busy}, 0);
    chk("t5_late_once", late_cnt - base_late, 1);
    chk("t5_no_oe", oe_cnt - base_oe, 0);

    // reset while waiting for the response
    do_reset();
    req_ready = 1'b1;
    a_in = 16'h0300;
    nrd  = 1'b0;
    wait_valid("t6_valid");
    tick();
    chk("t6_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    nrd   = 1'b1;
    tick();
    chk("t6_valid0", {31'b0, req_valid}, 0);
    chk("t6_busy0", {31'b0, busy}, 0);
    chk("t6_oe0", {31'b0, d_oe}, 0);
    chk("t6_addr0", {16'b0, req_addr}, 0);
    reset = 1'b0;
    tick();
    respond(8'h99);
    chk("t6_dout_ign", {24'b0, d_out}, 0);
    chk("t6_oe_ign", {31'b0, d_oe}, 0);
    chk("t6_late_ign", {31'b0, late}, 0);
    chk("t6_busy_ign", {31'b0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
